// File: rtl/tx_reorder_stage.sv
// ----------------------------------------------------------------------------
// tx_reorder_stage
//
// One stage of the transmit-side ring. Every word passes through a single
// output register, so the stage adds one cycle of latency. Words whose
// destination is STAGE_ID are re-emitted in strict round-robin source order,
// starting at source STAGE_ID. Words that arrive out of turn are parked in a
// small source-keyed list and popped when their source becomes the expected
// one. A frame is one header word followed by L further words, where L is the
// header's length field; one cycle after the last word, the stage raises its
// own bit in done_out.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   stall_in    downstream stall; freezes every register in the stage
//   stall_out   upstream stall (combinational): stall_in, or a word must be
//               parked while the list is full and nothing leaves it this cycle
//   data_in     {destination, payload}; the top SEL_W bits are the destination
//   src_in      source port of data_in
//   valid_in    data_in / src_in valid
//   data_out    registered output word
//   src_out     registered output source
//   valid_out   registered output valid
//   done_in     done vector from the previous stage
//   done_out    done_in, delayed one cycle, with bit STAGE_ID = this stage's done
//   skip_out    one-cycle pulse when the expected source is skipped by timeout
//   list_level  number of parked entries
//   busy        high while a frame is in progress (RUN)
// ----------------------------------------------------------------------------
module tx_reorder_stage #(
    parameter int STAGE_ID   = 0,
    parameter int PORTS      = 8,
    parameter int DATA_W     = 64,
    parameter int LEN_W      = 11,
    parameter int LEN_LSB    = 37,
    parameter int LIST_DEPTH = 2 * PORTS,
    parameter int TIMEOUT    = 0,
    localparam int SEL_W     = $clog2(PORTS),
    localparam int PORT_W    = SEL_W + DATA_W,
    localparam int LVL_W     = $clog2(LIST_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_in,
    output logic              stall_out,
    input  logic [PORT_W-1:0] data_in,
    input  logic [SEL_W-1:0]  src_in,
    input  logic              valid_in,
    output logic [PORT_W-1:0] data_out,
    output logic [SEL_W-1:0]  src_out,
    output logic              valid_out,
    input  logic [PORTS-1:0]  done_in,
    output logic [PORTS-1:0]  done_out,
    output logic              skip_out,
    output logic [LVL_W-1:0]  list_level,
    output logic              busy
);

    localparam int IDX_W = (LIST_DEPTH > 1) ? $clog2(LIST_DEPTH) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SEL_W-1:0] STAGE_SEL = SEL_W'(STAGE_ID);

    typedef enum logic {IDLE, RUN} state_t;

    // ---------------- state ----------------
    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   exp_reg, exp_next;
    logic [LEN_W-1:0]   rem_reg, rem_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [LVL_W-1:0]   level_reg;

    logic [PORT_W-1:0]  data_out_reg;
    logic [SEL_W-1:0]   src_out_reg;
    logic               valid_out_reg;
    logic [PORTS-1:0]   done_out_reg;
    logic               skip_out_reg;

    // Parking list, kept compacted in insertion order: index 0 is the oldest
    // entry, so the lowest matching index is the oldest entry for a key.
    logic [LIST_DEPTH-1:0] ent_vld_reg, ent_vld_next;
    logic [SEL_W-1:0]      ent_src_reg  [0:LIST_DEPTH-1];
    logic [SEL_W-1:0]      ent_src_next [0:LIST_DEPTH-1];
    logic [PORT_W-1:0]     ent_data_reg [0:LIST_DEPTH-1];
    logic [PORT_W-1:0]     ent_data_next[0:LIST_DEPTH-1];

    // ---------------- input classification ----------------
    logic own, foreign, src_match;
    assign own       = valid_in && (data_in[PORT_W-1 -: SEL_W] == STAGE_SEL);
    assign foreign   = valid_in && !own;
    assign src_match = (src_in == exp_reg);

    // ---------------- list lookup ----------------
    logic [LIST_DEPTH-1:0] match;
    logic                  hit;
    logic [IDX_W-1:0]      hit_idx;
    logic [PORT_W-1:0]     hit_data;
    logic [SEL_W-1:0]      hit_src;

    for (genvar gi = 0; gi < LIST_DEPTH; gi++) begin : g_match
        assign match[gi] = ent_vld_reg[gi] && (ent_src_reg[gi] == exp_reg);
    end

    assign hit = |match;

    always_comb begin
        hit_idx = '0;
        for (int i = LIST_DEPTH - 1; i >= 0; i--) begin
            if (match[i]) hit_idx = IDX_W'(i);
        end
    end

    assign hit_data = ent_data_reg[hit_idx];
    assign hit_src  = ent_src_reg[hit_idx];

    // ---------------- control ----------------
    logic out_in, out_list, list_rd, list_wr, park, own_emit, skip, done_now;
    logic full;
    logic [SEL_W-1:0] exp_inc;
    logic [CNT_W:0]   cnt_plus;
    logic             timeout_due;

    assign exp_inc     = (exp_reg == SEL_W'(PORTS - 1)) ? '0 : exp_reg + 1'b1;
    assign cnt_plus    = {1'b0, cnt_reg} + 1'b1;
    assign timeout_due = (TIMEOUT != 0) && (cnt_plus >= (CNT_W + 1)'(TIMEOUT));
    assign full        = (level_reg == LVL_W'(LIST_DEPTH));

    always_comb begin
        out_in     = 1'b0;
        out_list   = 1'b0;
        list_rd    = 1'b0;
        park       = 1'b0;
        own_emit   = 1'b0;
        skip       = 1'b0;
        done_now   = 1'b0;
        state_next = state_reg;
        exp_next   = exp_reg;
        rem_next   = rem_reg;
        cnt_next   = '0;
        case (state_reg)
            IDLE: begin
                if (foreign) begin
                    out_in = 1'b1;
                end else if (own && src_match) begin
                    out_in     = 1'b1;
                    own_emit   = 1'b1;
                    rem_next   = data_in[LEN_LSB +: LEN_W];
                    state_next = RUN;
                end else if (hit) begin
                    // A parked header for the expected source starts the frame.
                    out_list   = 1'b1;
                    list_rd    = 1'b1;
                    own_emit   = 1'b1;
                    park       = own;
                    rem_next   = hit_data[LEN_LSB +: LEN_W];
                    state_next = RUN;
                end else begin
                    park = own;
                end
                if (own_emit) exp_next = exp_inc;
            end
            RUN: begin
                if (rem_reg == '0) begin
                    // Finishing cycle: no pops, own words are parked.
                    done_now   = 1'b1;
                    exp_next   = STAGE_SEL;
                    state_next = IDLE;
                    out_in     = foreign;
                    park       = own;
                end else begin
                    if (foreign) begin
                        out_in = 1'b1;
                    end else if (hit) begin
                        out_list = 1'b1;
                        list_rd  = 1'b1;
                        own_emit = 1'b1;
                        park     = own;
                    end else if (own && src_match) begin
                        out_in   = 1'b1;
                        own_emit = 1'b1;
                    end else begin
                        park = own;
                    end

                    if (own_emit) begin
                        exp_next = exp_inc;
                        rem_next = rem_reg - 1'b1;
                    end else if (timeout_due && !foreign) begin
                        // The missing source forfeits its slot in the frame.
                        skip     = 1'b1;
                        exp_next = exp_inc;
                        rem_next = rem_reg - 1'b1;
                    end else if ((TIMEOUT != 0) && (cnt_reg != CNT_W'(TIMEOUT))) begin
                        cnt_next = cnt_reg + 1'b1;
                    end else begin
                        // Saturate while a foreign word holds off the skip.
                        cnt_next = cnt_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A simultaneous pop frees a slot, so a full list can still accept a park.
    assign stall_out = stall_in | (park && full && !list_rd);
    assign list_wr   = park && !stall_out;

    // ---------------- list next-state ----------------
    logic [LVL_W-1:0] wpos;
    assign wpos = level_reg - LVL_W'(list_rd);

    for (genvar gi = 0; gi < LIST_DEPTH; gi++) begin : g_ent
        logic              up_vld;
        logic [SEL_W-1:0]  up_src;
        logic [PORT_W-1:0] up_data;
        logic              shift_sel;
        logic              wr_here;

        if (gi == LIST_DEPTH - 1) begin : g_top
            assign up_vld  = 1'b0;
            assign up_src  = '0;
            assign up_data = '0;
        end else begin : g_mid
            assign up_vld  = ent_vld_reg[gi+1];
            assign up_src  = ent_src_reg[gi+1];
            assign up_data = ent_data_reg[gi+1];
        end

        // Entries at and above the popped one slide down by one.
        assign shift_sel = list_rd && (IDX_W'(gi) >= hit_idx);
        assign wr_here   = list_wr && (wpos == LVL_W'(gi));

        assign ent_vld_next[gi]  = wr_here | (shift_sel ? up_vld : ent_vld_reg[gi]);
        assign ent_src_next[gi]  = wr_here ? src_in :
                                   (shift_sel ? up_src : ent_src_reg[gi]);
        assign ent_data_next[gi] = wr_here ? data_in :
                                   (shift_sel ? up_data : ent_data_reg[gi]);
    end

    // ---------------- registers ----------------
    logic [PORTS-1:0] done_vec;
    always_comb begin
        done_vec           = done_in;
        done_vec[STAGE_ID] = done_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            exp_reg       <= STAGE_SEL;
            rem_reg       <= '0;
            cnt_reg       <= '0;
            level_reg     <= '0;
            ent_vld_reg   <= '0;
            data_out_reg  <= '0;
            src_out_reg   <= '0;
            valid_out_reg <= 1'b0;
            done_out_reg  <= '0;
            skip_out_reg  <= 1'b0;
        end else if (!stall_in) begin
            state_reg     <= state_next;
            exp_reg       <= exp_next;
            rem_reg       <= rem_next;
            cnt_reg       <= cnt_next;
            level_reg     <= level_reg + LVL_W'(list_wr) - LVL_W'(list_rd);
            ent_vld_reg   <= ent_vld_next;
            valid_out_reg <= out_in | out_list;
            if (out_in) begin
                data_out_reg <= data_in;
                src_out_reg  <= src_in;
            end else if (out_list) begin
                data_out_reg <= hit_data;
                src_out_reg  <= hit_src;
            end
            done_out_reg  <= done_vec;
            skip_out_reg  <= skip;
        end
    end

    // Payload storage needs no reset: the valid bits alone define occupancy.
    always_ff @(posedge clk) begin
        if (!stall_in) begin
            ent_src_reg  <= ent_src_next;
            ent_data_reg <= ent_data_next;
        end
    end

    assign data_out   = data_out_reg;
    assign src_out    = src_out_reg;
    assign valid_out  = valid_out_reg;
    assign done_out   = done_out_reg;
    assign skip_out   = skip_out_reg;
    assign list_level = level_reg;
    assign busy       = (state_reg == RUN);

endmodule

// File: tb/tb_tx_reorder_stage.sv
// ----------------------------------------------------------------------------
// tb_tx_reorder_stage
//
// Directed bench for tx_reorder_stage with PORTS=4, STAGE_ID=1, LIST_DEPTH=2,
// TIMEOUT=5. Stimulus pushes the expected output words into a queue in the
// order they must leave the stage; a monitor pops and compares each word the
// stage delivers (valid_out while the downstream is not stalled). Status
// outputs are checked inline against hand-computed values.
// ----------------------------------------------------------------------------
module tb_tx_reorder_stage;

    localparam int PORTS      = 4;
    localparam int STAGE_ID   = 1;
    localparam int DATA_W     = 64;
    localparam int LEN_W      = 11;
    localparam int LEN_LSB    = 37;
    localparam int LIST_DEPTH = 2;
    localparam int TIMEOUT    = 5;
    localparam int SEL_W      = 2;
    localparam int PORT_W     = SEL_W + DATA_W;
    localparam int LVL_W      = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stall_in;
    logic              stall_out;
    logic [PORT_W-1:0] data_in;
    logic [SEL_W-1:0]  src_in;
    logic              valid_in;
    logic [PORT_W-1:0] data_out;
    logic [SEL_W-1:0]  src_out;
    logic              valid_out;
    logic [PORTS-1:0]  done_in;
    logic [PORTS-1:0]  done_out;
    logic              skip_out;
    logic [LVL_W-1:0]  list_level;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;
    logic [SEL_W+PORT_W-1:0] want_q[$];

    tx_reorder_stage #(
        .STAGE_ID  (STAGE_ID),
        .PORTS     (PORTS),
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .LEN_LSB   (LEN_LSB),
        .LIST_DEPTH(LIST_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_in  (stall_in),
        .stall_out (stall_out),
        .data_in   (data_in),
        .src_in    (src_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .src_out   (src_out),
        .valid_out (valid_out),
        .done_in   (done_in),
        .done_out  (done_out),
        .skip_out  (skip_out),
        .list_level(list_level),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic logic [PORT_W-1:0] mk(input int dest, input int len, input int tag);
        logic [PORT_W-1:0] w;
        w = '0;
        w[PORT_W-1 -: SEL_W]  = SEL_W'(dest);
        w[LEN_LSB +: LEN_W]   = LEN_W'(len);
        w[15:0]               = 16'(tag);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PORT_W-1:0] w, input int src);
        data_in  = w;
        src_in   = SEL_W'(src);
        valid_in = 1'b1;
    endtask

    task automatic idle_in();
        data_in  = '0;
        src_in   = '0;
        valid_in = 1'b0;
    endtask

    task automatic want(input int src, input logic [PORT_W-1:0] w);
        want_q.push_back({SEL_W'(src), w});
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [SEL_W+PORT_W-1:0] w;
        if (rst_n === 1'b1 && valid_out === 1'b1 && stall_in === 1'b0) begin
            n_chk++;
            if (want_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_word: unexpected word src=%0h data=%0h", src_out, data_out);
            end else begin
                w = want_q.pop_front();
                if ({src_out, data_out} !== w) begin
                    n_fail++;
                    $display("FAIL out_word: got src=%0h data=%0h, expected src=%0h data=%0h",
                             src_out, data_out, w[SEL_W+PORT_W-1 -: SEL_W], w[PORT_W-1:0]);
                end else begin
                    $display("out src=%0h data=%0h", src_out, data_out);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [PORT_W-1:0] a1, a2, a3, a4;
        logic [PORT_W-1:0] b1, b2, b3;
        logic [PORT_W-1:0] c1, c2, c3, cf;
        logic [PORT_W-1:0] d0, d1, d2, d3;
        logic [PORT_W-1:0] e1, e3;
        logic [PORT_W-1:0] s1, s2, s3;
        logic [PORT_W-1:0] r1, r3, q1, q2;

        rst_n    = 1'b0;
        stall_in = 1'b0;
        done_in  = 4'b0101;
        idle_in();
        step();
        step();
        chk("rst_valid_out",  valid_out,  0);
        chk("rst_data_out",   data_out,   0);
        chk("rst_src_out",    src_out,    0);
        chk("rst_done_out",   done_out,   0);
        chk("rst_skip_out",   skip_out,   0);
        chk("rst_list_level", list_level, 0);
        chk("rst_busy",       busy,       0);
        chk("rst_stall_out",  stall_out,  0);
        rst_n = 1'b1;
        step();

        // In-order frame 1,2,3 (len 2), then a len-0 header parked during the
        // finishing cycle and popped from IDLE as a single-word frame.
        a1 = mk(1, 2, 'h101); a2 = mk(1, 0, 'h102); a3 = mk(1, 0, 'h103); a4 = mk(1, 0, 'h104);
        want(1, a1); want(2, a2); want(3, a3); want(1, a4);
        send(a1, 1); step();
        send(a2, 2); step();
        send(a3, 3); step();
        chk("t1_busy_last", busy, 1);
        send(a4, 1); step();
        chk("t1_done",       done_out,   4'b0111);
        chk("t1_park_fin",   list_level, 1);
        chk("t1_idle",       busy,       0);
        idle_in(); step();
        chk("t1_done_clr",   done_out,   4'b0101);
        chk("t1_idle_pop",   list_level, 0);
        chk("t1_busy_pop",   busy,       1);
        step();
        chk("t1_done_len0",  done_out,   4'b0111);
        step();

        // Reversed arrival 3,2,1: two parks, then two pops.
        b3 = mk(1, 0, 'h203); b2 = mk(1, 0, 'h202); b1 = mk(1, 2, 'h201);
        want(1, b1); want(2, b2); want(3, b3);
        send(b3, 3); step();
        chk("t2_level1", list_level, 1);
        send(b2, 2); step();
        chk("t2_level2", list_level, 2);
        send(b1, 1); #1;
        chk("t2_no_stall", stall_out, 0);
        step();
        idle_in(); step();
        chk("t2_pop1", list_level, 1);
        step();
        chk("t2_pop2", list_level, 0);
        step();
        chk("t2_done", done_out, 4'b0111);
        step();

        // Foreign word collides with a list hit: foreign goes first.
        c2 = mk(1, 0, 'h302); c1 = mk(1, 2, 'h301); cf = mk(0, 5, 'h3F0); c3 = mk(1, 0, 'h303);
        want(1, c1); want(3, cf); want(2, c2); want(3, c3);
        send(c2, 2); step();
        send(c1, 1); step();
        send(cf, 3); step();
        chk("t3_pop_deferred", list_level, 1);
        idle_in(); step();
        chk("t3_pop_done", list_level, 0);
        send(c3, 3); step();
        idle_in(); step();
        chk("t3_done", done_out, 4'b0111);
        step();

        // Full list: a non-expected own word is held off with stall_out.
        d2 = mk(1, 0, 'h402); d3 = mk(1, 0, 'h403); d0 = mk(1, 0, 'h400); d1 = mk(1, 3, 'h401);
        want(1, d1); want(2, d2); want(3, d3); want(0, d0);
        send(d2, 2); step();
        send(d3, 3); step();
        chk("t4_full", list_level, 2);
        send(d0, 0); #1;
        chk("t4_stall", stall_out, 1);
        step();
        chk("t4_held_level", list_level, 2);
        chk("t4_held_valid", valid_out,  0);
        chk("t4_stall_hold", stall_out,  1);
        send(d1, 1); #1;
        chk("t4_release", stall_out, 0);
        step();
        send(d0, 0); #1;
        chk("t4_rdwr_full", stall_out, 0);
        step();
        chk("t4_level_swap", list_level, 2);
        idle_in(); step();
        chk("t4_level1", list_level, 1);
        step();
        chk("t4_level0", list_level, 0);
        step();
        chk("t4_done", done_out, 4'b0111);
        step();

        // Source 2 never arrives: skipped after 5 idle RUN cycles.
        e3 = mk(1, 0, 'h503); e1 = mk(1, 2, 'h501);
        want(1, e1); want(3, e3);
        send(e3, 3); step();
        send(e1, 1); step();
        idle_in();
        step(); step(); step(); step();
        chk("t5_no_skip_yet", skip_out, 0);
        step();
        chk("t5_skip",       skip_out,   1);
        chk("t5_skip_level", list_level, 1);
        step();
        chk("t5_skip_clr",   skip_out,   0);
        chk("t5_popped",     list_level, 0);
        step();
        chk("t5_done", done_out, 4'b0111);
        step();

        // Downstream stall for 3 cycles mid-frame.
        s1 = mk(1, 2, 'h601); s2 = mk(1, 0, 'h602); s3 = mk(1, 0, 'h603);
        want(1, s1); want(2, s2); want(3, s3);
        send(s1, 1); step();
        send(s2, 2); step();
        stall_in = 1'b1;
        done_in  = 4'b1111;
        send(s3, 3); #1;
        chk("t6_stall_out", stall_out, 1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t6_frz_valid", valid_out, 1);
            chk("t6_frz_src",   src_out,   2);
            chk("t6_frz_data",  data_out,  s2);
            chk("t6_frz_done",  done_out,  4'b0101);
        end
        stall_in = 1'b0;
        done_in  = 4'b0101;
        step();
        idle_in(); step();
        chk("t6_done", done_out, 4'b0111);
        step();

        // Reset mid-frame, then a fresh frame proves exp and list restarted.
        r3 = mk(1, 0, 'h703); r1 = mk(1, 2, 'h701);
        want(1, r1);
        send(r3, 3); step();
        send(r1, 1); step();
        idle_in();
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", valid_out,  0);
        chk("t7_rst_data",  data_out,   0);
        chk("t7_rst_level", list_level, 0);
        chk("t7_rst_busy",  busy,       0);
        chk("t7_rst_done",  done_out,   0);
        step(); step();
        rst_n = 1'b1;
        q2 = mk(1, 0, 'h712); q1 = mk(1, 1, 'h711);
        want(1, q1); want(2, q2);
        send(q2, 2); step();
        chk("t7_park", list_level, 1);
        send(q1, 1); step();
        idle_in(); step();
        chk("t7_pop", list_level, 0);
        step();
        chk("t7_done", done_out, 4'b0111);
        chk("t7_idle", busy,     0);
        step(); step(); step();

        chk("queue_drained", want_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
